stm_gain_reader: RTL and testbench

- Downstream consumer of the gain-STM BRAM read port (64-bit words, 4 × 16-bit transducer entries per word, 64 words per pattern).
- On a start pulse with a pattern index, drives the BRAM read address and unpacks the returned words.
- Emits one transducer's intensity/phase per cycle, in ascending transducer order, to the drive/modulation stage.

---
 rtl/stm_pkg.sv | 34 +++
 rtl/stm_lane_unpacker.sv | 37 +++
 rtl/stm_gain_reader.sv | 172 +++++++++++++++++
 tb/tb_stm_gain_reader.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/stm_pkg.sv
// Shared constants and types for the gain-STM read path: pattern geometry,
// lane/word packing, read-pipeline depth and the reader FSM state type.
package stm_pkg;

  localparam int NUM_TRANSDUCERS   = 249;
  localparam int WORDS_PER_PATTERN = 64;
  localparam int LANES             = 4;
  localparam int LANE_WIDTH        = 16;
  localparam int WORD_WIDTH        = LANES * LANE_WIDTH;
  localparam int IDX_WIDTH         = 10;
  localparam int WORD_ADDR_WIDTH   = $clog2(WORDS_PER_PATTERN);
  localparam int ADDR_WIDTH        = IDX_WIDTH + WORD_ADDR_WIDTH;
  // Edges from the address register to the lane-mux output register
  // (one BRAM register plus the lane-mux register).
  localparam int RD_LATENCY        = 2;
  localparam int TIDX_WIDTH        = 8;

  typedef logic [7:0]                 intensity_t;
  typedef logic [7:0]                 phase_t;
  typedef logic [TIDX_WIDTH-1:0]      tidx_t;
  typedef logic [$clog2(LANES)-1:0]   lane_t;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} stm_rd_state_t;

  // One in-flight output slot travelling alongside the BRAM read.
  typedef struct packed {
    logic  valid;
    lane_t lane;
    tidx_t tIdx;
  } rd_token_t;

  localparam tidx_t LAST_TIDX = tidx_t'(NUM_TRANSDUCERS - 1);

endpackage

// File: rtl/stm_lane_unpacker.sv
// Selects one 16-bit transducer entry out of a 64-bit BRAM word and
// registers its intensity (upper byte) and phase (lower byte).
module stm_lane_unpacker
  import stm_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WORD_WIDTH-1:0] word_i,
  input  lane_t                 lane_i,
  input  logic                  load_i,
  output intensity_t            intensity_o,
  output phase_t                phase_o
);

  logic [LANES-1:0][LANE_WIDTH-1:0] lanes;
  logic [LANE_WIDTH-1:0]            laneSel;
  intensity_t                       intensity_q;
  phase_t                           phase_q;

  assign lanes   = word_i;
  assign laneSel = lanes[lane_i];

  // Capture the selected lane only when a valid slot reaches this stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      intensity_q <= '0;
      phase_q     <= '0;
    end else if (load_i) begin
      intensity_q <= laneSel[15:8];
      phase_q     <= laneSel[7:0];
    end
  end

  assign intensity_o = intensity_q;
  assign phase_o     = phase_q;

endmodule

// File: rtl/stm_gain_reader.sv
// Gain-STM pattern reader: on start, walks the 63 used words of the chosen
// pattern in BRAM and emits one transducer (intensity/phase/index) per cycle.
// Optional macro STM_GAIN_READER_OUTREG_EN adds one output register stage.
module stm_gain_reader
  import stm_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IDX_WIDTH-1:0]  idx,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] addr,
  input  logic [WORD_WIDTH-1:0] din,
  output logic                  dout_valid,
  output intensity_t            intensity,
  output phase_t                phase,
  output tidx_t                 dout_idx,
  output logic                  done
);

  stm_rd_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  tidx_t                 issueCnt_q, issueCnt_d;
  rd_token_t             issueTok;
  rd_token_t             pipe_q [RD_LATENCY];
  rd_token_t             pipeOut;
  logic                  pipeBusy;
  logic                  accept;
  logic                  doutValid_q;
  tidx_t                 doutIdx_q;
  intensity_t            unpIntensity;
  phase_t                unpPhase;
  logic                  doneRaw;

  assign pipeOut = pipe_q[RD_LATENCY-1];
  assign doneRaw = (state_q == DONE);
  assign accept  = (state_q == IDLE) && start && !busy;
  assign addr    = addr_q;

  // True while any output slot is still travelling towards the lane mux.
  always_comb begin
    pipeBusy = 1'b0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      pipeBusy = pipeBusy | pipe_q[i].valid;
    end
  end

  // Next-state, address stepping and per-cycle slot issue; the address moves
  // on every fourth slot so each word is held for its four lanes.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    issueCnt_d = issueCnt_q;
    issueTok   = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d         = {idx, WORD_ADDR_WIDTH'(0)};
          issueTok.valid = 1'b1;
          issueCnt_d     = tidx_t'(1);
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        issueTok.valid = 1'b1;
        issueTok.lane  = lane_t'(issueCnt_q);
        issueTok.tIdx  = issueCnt_q;
        issueCnt_d     = issueCnt_q + tidx_t'(1);
        if (lane_t'(issueCnt_q) == '0) begin
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
        if (issueCnt_q == LAST_TIDX) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!pipeBusy) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, address and slot-tracking shift register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      issueCnt_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      issueCnt_q <= issueCnt_d;
      pipe_q[0]  <= issueTok;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  // Valid and transducer index registered in step with the lane-mux data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      doutValid_q <= 1'b0;
      doutIdx_q   <= '0;
    end else begin
      doutValid_q <= pipeOut.valid;
      if (pipeOut.valid) begin
        doutIdx_q <= pipeOut.tIdx;
      end
    end
  end

  stm_lane_unpacker u_unpacker (
    .clk         (clk),
    .rst_n       (rst_n),
    .word_i      (din),
    .lane_i      (pipeOut.lane),
    .load_i      (pipeOut.valid),
    .intensity_o (unpIntensity),
    .phase_o     (unpPhase)
  );

`ifdef STM_GAIN_READER_OUTREG_EN
  logic       outValid_q;
  tidx_t      outIdx_q;
  intensity_t outIntensity_q;
  phase_t     outPhase_q;
  logic       outDone_q;

  // Extra output stage; busy stays high until the delayed done has shown.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outValid_q     <= 1'b0;
      outIdx_q       <= '0;
      outIntensity_q <= '0;
      outPhase_q     <= '0;
      outDone_q      <= 1'b0;
    end else begin
      outValid_q     <= doutValid_q;
      outIdx_q       <= doutIdx_q;
      outIntensity_q <= unpIntensity;
      outPhase_q     <= unpPhase;
      outDone_q      <= doneRaw;
    end
  end

  assign dout_valid = outValid_q;
  assign dout_idx   = outIdx_q;
  assign intensity  = outIntensity_q;
  assign phase      = outPhase_q;
  assign done       = outDone_q;
  assign busy       = (state_q != IDLE) || outDone_q;
`else
  assign dout_valid = doutValid_q;
  assign dout_idx   = doutIdx_q;
  assign intensity  = unpIntensity;
  assign phase      = unpPhase;
  assign done       = doneRaw;
  assign busy       = (state_q != IDLE);
`endif

endmodule

// File: tb/tb_stm_gain_reader.sv
// Directed bench for stm_gain_reader with a one-register BRAM model whose
// word k lane j holds {4k+j, ~(4k+j)}. Honours STM_GAIN_READER_OUTREG_EN.
`timescale 1ns/1ps
module tb_stm_gain_reader;
  import stm_pkg::*;

`ifdef STM_GAIN_READER_OUTREG_EN
  localparam int OUT_DLY = 1;
`else
  localparam int OUT_DLY = 0;
`endif
  localparam int FIRST_VALID = 3 + OUT_DLY;
  localparam int LAST_VALID  = FIRST_VALID + 248;
  localparam int DONE_CYCLE  = LAST_VALID + 1;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  idx   = '0;
  logic        busy;
  logic [15:0] addr;
  logic [63:0] din;
  logic        dout_valid;
  logic [7:0]  intensity;
  logic [7:0]  phase;
  logic [7:0]  dout_idx;
  logic        done;

  int testsRun    = 0;
  int testsFailed = 0;

  stm_gain_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .idx        (idx),
    .busy       (busy),
    .addr       (addr),
    .din        (din),
    .dout_valid (dout_valid),
    .intensity  (intensity),
    .phase      (phase),
    .dout_idx   (dout_idx),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] bramWord(input logic [5:0] k);
    logic [63:0] w;
    logic [7:0]  t;
    w = '0;
    for (int j = 0; j < 4; j++) begin
      t = 8'(4 * k + j);
      w[16*j +: 16] = {t, ~t};
    end
    return w;
  endfunction

  // Synchronous BRAM: one register between addr and din.
  always @(posedge clk) din <= bramWord(addr[5:0]);

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic startV, input logic [9:0] idxV);
    start = startV;
    idx   = idxV;
  endtask

  task automatic checkAllZero(input string where);
    checkOutput({where, " busy"},       32'(busy),       32'(0));
    checkOutput({where, " addr"},       32'(addr),       32'(0));
    checkOutput({where, " dout_valid"}, 32'(dout_valid), 32'(0));
    checkOutput({where, " intensity"},  32'(intensity),  32'(0));
    checkOutput({where, " phase"},      32'(phase),      32'(0));
    checkOutput({where, " dout_idx"},   32'(dout_idx),   32'(0));
    checkOutput({where, " done"},       32'(done),       32'(0));
  endtask

  // Start a sequence at cycle 0 and check every cycle up to one past done.
  // pokeCycle: drive start with pokeIdx during that cycle (must be ignored).
  // abortCycle: pull reset during that cycle and check the cleared outputs.
  task automatic runSequence(input logic [9:0] idxV, input int pokeCycle,
                             input logic [9:0] pokeIdx, input int abortCycle);
    logic [15:0] base;
    logic [15:0] expAddr;
    logic [7:0]  expT;
    logic [7:0]  expPh;
    logic        expValid;
    int          wordK;
    base = {idxV, 6'd0};
    @(negedge clk);
    applyStimulus(1'b1, idxV);
    for (int c = 1; c <= DONE_CYCLE + 1; c++) begin
      @(negedge clk);
      applyStimulus(1'b0, idx);
      if (c == pokeCycle) applyStimulus(1'b1, pokeIdx);
      wordK = (c - 1) / 4;
      if (wordK > 62) wordK = 62;
      expAddr  = base + 16'(wordK);
      expValid = (c >= FIRST_VALID) && (c <= LAST_VALID);
      checkOutput($sformatf("idx%0d c%0d addr", idxV, c), 32'(addr), 32'(expAddr));
      checkOutput($sformatf("idx%0d c%0d dout_valid", idxV, c), 32'(dout_valid), 32'(expValid));
      checkOutput($sformatf("idx%0d c%0d busy", idxV, c), 32'(busy), 32'(c <= DONE_CYCLE));
      checkOutput($sformatf("idx%0d c%0d done", idxV, c), 32'(done), 32'(c == DONE_CYCLE));
      if (expValid) begin
        expT  = 8'(c - FIRST_VALID);
        expPh = ~expT;
        checkOutput($sformatf("idx%0d c%0d dout_idx", idxV, c), 32'(dout_idx), 32'(expT));
        checkOutput($sformatf("idx%0d c%0d intensity", idxV, c), 32'(intensity), 32'(expT));
        checkOutput($sformatf("idx%0d c%0d phase", idxV, c), 32'(phase), 32'(expPh));
      end
      if (c == abortCycle) begin
        rst_n = 1'b0;
        @(negedge clk);
        checkAllZero("abort");
        rst_n = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    applyStimulus(1'b0, 10'd0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;

    // idx 0, with an ignored start (idx 7) at cycle 100
    runSequence(10'd0, 100, 10'd7, 0);
    // fresh start after busy fell: base 448
    runSequence(10'd7, 0, 10'd0, 0);
    // base 320, last output t=248 -> 0xF8/0x07
    runSequence(10'd5, 0, 10'd0, 0);
    // top pattern 0xFFC0..0xFFFE, start on the last busy cycle is ignored
    runSequence(10'd1023, DONE_CYCLE, 10'd9, 0);
    // reset mid-burst
    runSequence(10'd3, 0, 10'd0, 50);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput($sformatf("post-abort %0d done", i), 32'(done), 32'(0));
      checkOutput($sformatf("post-abort %0d busy", i), 32'(busy), 32'(0));
      checkOutput($sformatf("post-abort %0d dout_valid", i), 32'(dout_valid), 32'(0));
    end
    // full sequence after the abort
    runSequence(10'd2, 0, 10'd0, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
